// File: rtl/bw_test_sequencer.sv
// bw_test_sequencer
// -----------------
// Drives a traffic generator through repeated write / read / write-then-read /
// concurrent bandwidth runs. It collects the min/max/sum of the per-phase
// durations that the generator reports, and counts completed iterations.
//
// Command handshake: cmd_ready is high only in IDLE. A command is accepted on
// a rising clk edge where cmd_start && cmd_ready. A cmd_start seen while
// cmd_ready is low is dropped; it is not queued.
//
// Ports
//   clk, resetn        clock (rising edge), synchronous active-low reset
//   cmd_start          one-cycle start request
//   cmd_mode           0 write, 1 read, 2 write-then-read, 3 concurrent
//   cmd_iters          iteration count, 0 behaves as 1
//   cmd_ready          idle and able to accept cmd_start
//   tg_start_write/read  one-cycle engine start pulses (registered)
//   tg_write/read_busy   engine busy flags
//   tg_write/read_time   last duration of each engine, in cycles
//   wr_min/max/sum       write statistics for the current run
//   rd_min/max/sum       read statistics for the current run
//   iter_done            completed iterations in the current run
//   done               one-cycle pulse at the end of a run
//   error              sticky timeout flag, cleared on an accepted command
//   state_dbg          current FSM state, for debug and checker binding
module bw_test_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_start,
    input  logic [1:0]  cmd_mode,
    input  logic [15:0] cmd_iters,
    output logic        cmd_ready,
    output logic        tg_start_write,
    output logic        tg_start_read,
    input  logic        tg_write_busy,
    input  logic        tg_read_busy,
    input  logic [31:0] tg_write_time,
    input  logic [31:0] tg_read_time,
    output logic [31:0] wr_min,
    output logic [31:0] wr_max,
    output logic [47:0] wr_sum,
    output logic [31:0] rd_min,
    output logic [31:0] rd_max,
    output logic [47:0] rd_sum,
    output logic [15:0] iter_done,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_ACCUM  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RD     = 2'd1;
    localparam logic [1:0] MODE_WR_RD  = 2'd2;
    localparam logic [1:0] MODE_CONC   = 2'd3;
    localparam logic [31:0] MIN_INIT   = 32'hFFFF_FFFF;

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [15:0] iters_q;
    logic        phase_rd_q;     // 0: write phase, 1: read phase
    logic        wr_act_q;       // write engine was started this phase
    logic        rd_act_q;       // read engine was started this phase
    logic [31:0] tmo_q;
    logic        start_wr_q;
    logic        start_rd_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] iter_done_q;
    logic [31:0] wr_min_q, wr_max_q, rd_min_q, rd_max_q;
    logic [47:0] wr_sum_q, rd_sum_q;

    // Next-value helpers
    logic [1:0]  issue_mode_d;
    logic        issue_rd_d;
    logic        issue_wr_go_d;
    logic        issue_rd_go_d;
    logic        phase_done_d;
    logic [31:0] tmo_d;
    logic [15:0] iter_done_d;
    logic [31:0] wr_min_d, wr_max_d, rd_min_d, rd_max_d;
    logic [47:0] wr_sum_d, rd_sum_d;

    always_comb begin
        // The start pulses are registered. They must be computed on the edge
        // that enters ISSUE, from the mode and phase that ISSUE will use.
        issue_mode_d = mode_q;
        issue_rd_d   = phase_rd_q;
        if (state_q == S_IDLE) begin
            issue_mode_d = cmd_mode;
            issue_rd_d   = (cmd_mode == MODE_RD);
        end else if (state_q == S_ACCUM) begin
            if (mode_q == MODE_WR_RD && !phase_rd_q) begin
                issue_rd_d = 1'b1;
            end else begin
                issue_rd_d = (mode_q == MODE_RD);
            end
        end
        issue_wr_go_d = !issue_rd_d || (issue_mode_d == MODE_CONC);
        issue_rd_go_d =  issue_rd_d || (issue_mode_d == MODE_CONC);

        phase_done_d = (!wr_act_q || !tg_write_busy) && (!rd_act_q || !tg_read_busy);
        tmo_d        = tmo_q + 32'd1;
        iter_done_d  = iter_done_q + 16'd1;

        // Strict compares, so an equal candidate leaves the register unchanged.
        wr_min_d = (tg_write_time < wr_min_q) ? tg_write_time : wr_min_q;
        wr_max_d = (tg_write_time > wr_max_q) ? tg_write_time : wr_max_q;
        rd_min_d = (tg_read_time  < rd_min_q) ? tg_read_time  : rd_min_q;
        rd_max_d = (tg_read_time  > rd_max_q) ? tg_read_time  : rd_max_q;
        wr_sum_d = wr_sum_q + {16'd0, tg_write_time};
        rd_sum_d = rd_sum_q + {16'd0, tg_read_time};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            iters_q     <= 16'd1;
            phase_rd_q  <= 1'b0;
            wr_act_q    <= 1'b0;
            rd_act_q    <= 1'b0;
            tmo_q       <= 32'd0;
            start_wr_q  <= 1'b0;
            start_rd_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            iter_done_q <= 16'd0;
            wr_min_q    <= MIN_INIT;
            wr_max_q    <= 32'd0;
            wr_sum_q    <= 48'd0;
            rd_min_q    <= MIN_INIT;
            rd_max_q    <= 32'd0;
            rd_sum_q    <= 48'd0;
        end else begin
            start_wr_q <= 1'b0;
            start_rd_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        mode_q      <= cmd_mode;
                        iters_q     <= (cmd_iters == 16'd0) ? 16'd1 : cmd_iters;
                        error_q     <= 1'b0;
                        iter_done_q <= 16'd0;
                        wr_min_q    <= MIN_INIT;
                        wr_max_q    <= 32'd0;
                        wr_sum_q    <= 48'd0;
                        rd_min_q    <= MIN_INIT;
                        rd_max_q    <= 32'd0;
                        rd_sum_q    <= 48'd0;
                        phase_rd_q  <= issue_rd_d;
                        start_wr_q  <= issue_wr_go_d;
                        start_rd_q  <= issue_rd_go_d;
                        wr_act_q    <= issue_wr_go_d;
                        rd_act_q    <= issue_rd_go_d;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= 32'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion wins over a timeout that lands on the same cycle.
                    if (phase_done_d) begin
                        state_q <= S_ACCUM;
                    end else if (tmo_d == TIMEOUT_CYCLES) begin
                        tmo_q   <= tmo_d;
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_ACCUM: begin
                    if (wr_act_q) begin
                        wr_min_q <= wr_min_d;
                        wr_max_q <= wr_max_d;
                        wr_sum_q <= wr_sum_d;
                    end
                    if (rd_act_q) begin
                        rd_min_q <= rd_min_d;
                        rd_max_q <= rd_max_d;
                        rd_sum_q <= rd_sum_d;
                    end
                    // In write-then-read mode, the write half alone does not
                    // complete an iteration.
                    if (mode_q == MODE_WR_RD && !phase_rd_q) begin
                        phase_rd_q <= issue_rd_d;
                        start_wr_q <= issue_wr_go_d;
                        start_rd_q <= issue_rd_go_d;
                        wr_act_q   <= issue_wr_go_d;
                        rd_act_q   <= issue_rd_go_d;
                        state_q    <= S_ISSUE;
                    end else begin
                        iter_done_q <= iter_done_d;
                        if (iter_done_d == iters_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            phase_rd_q <= issue_rd_d;
                            start_wr_q <= issue_wr_go_d;
                            start_rd_q <= issue_rd_go_d;
                            wr_act_q   <= issue_wr_go_d;
                            rd_act_q   <= issue_rd_go_d;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign tg_start_write = start_wr_q;
    assign tg_start_read  = start_rd_q;
    assign wr_min         = wr_min_q;
    assign wr_max         = wr_max_q;
    assign wr_sum         = wr_sum_q;
    assign rd_min         = rd_min_q;
    assign rd_max         = rd_max_q;
    assign rd_sum         = rd_sum_q;
    assign iter_done      = iter_done_q;
    assign done           = done_q;
    assign error          = error_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_bw_test_sequencer.sv
// Testbench for bw_test_sequencer.
// u_dut (default timeout) is driven by a traffic-generator model. Its start
// pulses and done pulses are checked against expected queues that the
// directed tests fill. u_tmo (timeout 16) is used for the timeout scenario.
module tb_bw_test_sequencer;

    typedef struct packed {
        logic [31:0] wr_min;
        logic [31:0] wr_max;
        logic [47:0] wr_sum;
        logic [31:0] rd_min;
        logic [31:0] rd_max;
        logic [47:0] rd_sum;
        logic [15:0] iter_done;
        logic        error;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic resetn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic        cmd_start;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_iters;
    logic        cmd_ready;
    logic        tg_start_write, tg_start_read;
    logic        tg_write_busy, tg_read_busy;
    logic [31:0] tg_write_time, tg_read_time;
    logic [31:0] wr_min, wr_max, rd_min, rd_max;
    logic [47:0] wr_sum, rd_sum;
    logic [15:0] iter_done;
    logic        done, error;
    logic [2:0]  state_dbg;

    // ---------------- timeout DUT signals ----------------
    logic        t_cmd_start;
    logic [1:0]  t_cmd_mode;
    logic [15:0] t_cmd_iters;
    logic        t_cmd_ready;
    logic        t_start_wr, t_start_rd;
    logic        t_wr_busy, t_rd_busy;
    logic [31:0] t_wr_time, t_rd_time;
    logic [31:0] t_wr_min, t_wr_max, t_rd_min, t_rd_max;
    logic [47:0] t_wr_sum, t_rd_sum;
    logic [15:0] t_iter_done;
    logic        t_done, t_error;
    logic [2:0]  t_state;

    bw_test_sequencer u_dut (
        .clk(clk), .resetn(resetn),
        .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_iters(cmd_iters),
        .cmd_ready(cmd_ready),
        .tg_start_write(tg_start_write), .tg_start_read(tg_start_read),
        .tg_write_busy(tg_write_busy), .tg_read_busy(tg_read_busy),
        .tg_write_time(tg_write_time), .tg_read_time(tg_read_time),
        .wr_min(wr_min), .wr_max(wr_max), .wr_sum(wr_sum),
        .rd_min(rd_min), .rd_max(rd_max), .rd_sum(rd_sum),
        .iter_done(iter_done), .done(done), .error(error),
        .state_dbg(state_dbg)
    );

    bw_test_sequencer #(.TIMEOUT_CYCLES(32'd16)) u_tmo (
        .clk(clk), .resetn(resetn),
        .cmd_start(t_cmd_start), .cmd_mode(t_cmd_mode), .cmd_iters(t_cmd_iters),
        .cmd_ready(t_cmd_ready),
        .tg_start_write(t_start_wr), .tg_start_read(t_start_rd),
        .tg_write_busy(t_wr_busy), .tg_read_busy(t_rd_busy),
        .tg_write_time(t_wr_time), .tg_read_time(t_rd_time),
        .wr_min(t_wr_min), .wr_max(t_wr_max), .wr_sum(t_wr_sum),
        .rd_min(t_rd_min), .rd_max(t_rd_max), .rd_sum(t_rd_sum),
        .iter_done(t_iter_done), .done(t_done), .error(t_error),
        .state_dbg(t_state)
    );

    // ---------------- scoreboard state ----------------
    exp_t        exp_q[$];
    logic [17:0] pls_q[$];     // {kind[1:0] = {rd,wr}, iter_done at pulse}
    int          wr_dur_q[$];
    int          rd_dur_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] wmn, input logic [31:0] wmx, input logic [47:0] ws,
                            input logic [31:0] rmn, input logic [31:0] rmx, input logic [47:0] rs,
                            input logic [15:0] it, input logic er);
        exp_t e;
        e.wr_min = wmn; e.wr_max = wmx; e.wr_sum = ws;
        e.rd_min = rmn; e.rd_max = rmx; e.rd_sum = rs;
        e.iter_done = it; e.error = er;
        exp_q.push_back(e);
    endtask

    // ---------------- traffic generator model ----------------
    initial begin
        int d;
        tg_write_busy = 1'b0;
        tg_write_time = 32'd0;
        forever begin
            @(negedge clk);
            if (tg_start_write === 1'b1) begin
                d = (wr_dur_q.size() > 0) ? wr_dur_q.pop_front() : 5;
                @(posedge clk);
                #1 tg_write_busy = 1'b1;
                repeat (d) @(posedge clk);
                #1;
                tg_write_busy = 1'b0;
                tg_write_time = d;
            end
        end
    end

    initial begin
        int d;
        tg_read_busy = 1'b0;
        tg_read_time = 32'd0;
        forever begin
            @(negedge clk);
            if (tg_start_read === 1'b1) begin
                d = (rd_dur_q.size() > 0) ? rd_dur_q.pop_front() : 5;
                @(posedge clk);
                #1 tg_read_busy = 1'b1;
                repeat (d) @(posedge clk);
                #1;
                tg_read_busy = 1'b0;
                tg_read_time = d;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [17:0] mon_p;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (tg_start_write === 1'b1 || tg_start_read === 1'b1) begin
            if (pls_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got w=%0b r=%0b required none", tg_start_write, tg_start_read);
            end else begin
                mon_p = pls_q.pop_front();
                check("pulse_kind", {62'd0, tg_start_read, tg_start_write}, {62'd0, mon_p[17:16]});
                check("pulse_iter_done", {48'd0, iter_done}, {48'd0, mon_p[15:0]});
                check("pulse_prior_busy_low", {62'd0, tg_read_busy, tg_write_busy}, 64'd0);
            end
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required 0 (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_min", {32'd0, wr_min}, {32'd0, mon_e.wr_min});
                check("wr_max", {32'd0, wr_max}, {32'd0, mon_e.wr_max});
                check("wr_sum", {16'd0, wr_sum}, {16'd0, mon_e.wr_sum});
                check("rd_min", {32'd0, rd_min}, {32'd0, mon_e.rd_min});
                check("rd_max", {32'd0, rd_max}, {32'd0, mon_e.rd_max});
                check("rd_sum", {16'd0, rd_sum}, {16'd0, mon_e.rd_sum});
                check("iter_done", {48'd0, iter_done}, {48'd0, mon_e.iter_done});
                check("error", {63'd0, error}, {63'd0, mon_e.error});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input logic [1:0] m, input logic [15:0] it);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_ready_wait", 64'd0, 64'd1);
        cmd_mode  = m;
        cmd_iters = it;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_run_end(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && pls_q.size() == 0 && cmd_ready === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_completes_in_budget", {63'd0, (n < budget)}, 64'd1);
    endtask

    task automatic wait_gen_idle();
        int n;
        n = 0;
        while ((tg_write_busy || tg_read_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("generator_idle", {63'd0, (n < 200)}, 64'd1);
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_start_write", {63'd0, tg_start_write}, 64'd0);
        check("rst_start_read", {63'd0, tg_start_read}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_iter_done", {48'd0, iter_done}, 64'd0);
        check("rst_wr_min", {32'd0, wr_min}, 64'hFFFF_FFFF);
        check("rst_wr_max", {32'd0, wr_max}, 64'd0);
        check("rst_wr_sum", {16'd0, wr_sum}, 64'd0);
        check("rst_rd_min", {32'd0, rd_min}, 64'hFFFF_FFFF);
        check("rst_rd_max", {32'd0, rd_max}, 64'd0);
        check("rst_rd_sum", {16'd0, rd_sum}, 64'd0);
        check("rst_state_idle", {61'd0, state_dbg}, 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        resetn      = 1'b0;
        cmd_start   = 1'b0;
        cmd_mode    = 2'd0;
        cmd_iters   = 16'd0;
        t_cmd_start = 1'b0;
        t_cmd_mode  = 2'd0;
        t_cmd_iters = 16'd0;
        t_wr_busy   = 1'b0;
        t_rd_busy   = 1'b0;
        t_wr_time   = 32'd0;
        t_rd_time   = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_values();
        check("rst_tmo_cmd_ready", {63'd0, t_cmd_ready}, 64'd1);
        resetn = 1'b1;
        @(negedge clk);

        // Mode 0, 3 iterations, durations 100/200/150.
        wr_dur_q = '{100, 200, 150};
        pls_q.push_back({2'b01, 16'd0});
        pls_q.push_back({2'b01, 16'd1});
        pls_q.push_back({2'b01, 16'd2});
        push_exp(32'd100, 32'd200, 48'd450, 32'hFFFF_FFFF, 32'd0, 48'd0, 16'd3, 1'b0);
        start_cmd(2'd0, 16'd3);
        wait_run_end(1000);

        // Mode 2, 2 iterations: W10 R20 W30 R5.
        wr_dur_q = '{10, 30};
        rd_dur_q = '{20, 5};
        pls_q.push_back({2'b01, 16'd0});
        pls_q.push_back({2'b10, 16'd0});
        pls_q.push_back({2'b01, 16'd1});
        pls_q.push_back({2'b10, 16'd1});
        push_exp(32'd10, 32'd30, 48'd40, 32'd5, 32'd20, 48'd25, 16'd2, 1'b0);
        start_cmd(2'd2, 16'd2);
        wait_run_end(500);

        // Mode 3, 1 iteration: write 50, read 80, both pulses together.
        wr_dur_q = '{50};
        rd_dur_q = '{80};
        pls_q.push_back({2'b11, 16'd0});
        push_exp(32'd50, 32'd50, 48'd50, 32'd80, 32'd80, 48'd80, 16'd1, 1'b0);
        start_cmd(2'd3, 16'd1);
        wait_run_end(300);

        // Mode 1, read 30; a second cmd_start during WAIT must be ignored.
        rd_dur_q = '{30};
        pls_q.push_back({2'b10, 16'd0});
        push_exp(32'hFFFF_FFFF, 32'd0, 48'd0, 32'd30, 32'd30, 48'd30, 16'd1, 1'b0);
        start_cmd(2'd1, 16'd1);
        repeat (5) @(negedge clk);
        check("ready_low_in_wait", {63'd0, cmd_ready}, 64'd0);
        cmd_mode  = 2'd0;
        cmd_iters = 16'd5;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_run_end(300);

        // Mode 0 with cmd_iters = 0 runs exactly one iteration.
        wr_dur_q = '{7};
        pls_q.push_back({2'b01, 16'd0});
        push_exp(32'd7, 32'd7, 48'd7, 32'hFFFF_FFFF, 32'd0, 48'd0, 16'd1, 1'b0);
        start_cmd(2'd0, 16'd0);
        wait_run_end(200);

        // Equal durations: min and max both settle on the shared value.
        wr_dur_q = '{12, 12};
        pls_q.push_back({2'b01, 16'd0});
        pls_q.push_back({2'b01, 16'd1});
        push_exp(32'd12, 32'd12, 48'd24, 32'hFFFF_FFFF, 32'd0, 48'd0, 16'd2, 1'b0);
        start_cmd(2'd0, 16'd2);
        wait_run_end(200);

        // Reset in the middle of a write phase: no done, reset values return.
        wr_dur_q = '{40};
        pls_q.push_back({2'b01, 16'd0});
        start_cmd(2'd0, 16'd1);
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_reset_values();
        wait_gen_idle();
        repeat (5) @(negedge clk);
        check("reset_no_pending_pulse", {32'd0, pls_q.size()}, 64'd0);

        // Timeout on u_tmo: read busy stuck high, mode 1.
        t_rd_busy   = 1'b1;
        t_cmd_mode  = 2'd1;
        t_cmd_iters = 16'd1;
        t_cmd_start = 1'b1;
        @(negedge clk);
        t_cmd_start = 1'b0;
        check("tmo_issue_read_pulse", {63'd0, t_start_rd}, 64'd1);
        check("tmo_issue_no_write", {63'd0, t_start_wr}, 64'd0);
        n = 0;
        while (t_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        // Sixteen WAIT cycles, then FINISH: done is sampled 17 cycles after ISSUE.
        check("tmo_done_latency", n, 64'd17);
        check("tmo_error", {63'd0, t_error}, 64'd1);
        check("tmo_iter_done", {48'd0, t_iter_done}, 64'd0);
        check("tmo_rd_sum", {16'd0, t_rd_sum}, 64'd0);
        check("tmo_rd_min", {32'd0, t_rd_min}, 64'hFFFF_FFFF);
        @(negedge clk);
        check("tmo_done_one_cycle", {63'd0, t_done}, 64'd0);
        check("tmo_error_sticky", {63'd0, t_error}, 64'd1);
        check("tmo_back_idle", {63'd0, t_cmd_ready}, 64'd1);

        // A new command clears the error; the read completes immediately.
        t_rd_busy   = 1'b0;
        t_rd_time   = 32'd9;
        t_cmd_start = 1'b1;
        @(negedge clk);
        t_cmd_start = 1'b0;
        check("tmo_error_cleared", {63'd0, t_error}, 64'd0);
        n = 0;
        while (t_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_rerun_done", {63'd0, t_done}, 64'd1);
        check("tmo_rerun_error", {63'd0, t_error}, 64'd0);
        check("tmo_rerun_iter", {48'd0, t_iter_done}, 64'd1);
        check("tmo_rerun_rd_sum", {16'd0, t_rd_sum}, 64'd9);

        repeat (5) @(negedge clk);
        check("exp_q_drained", {32'd0, exp_q.size()}, 64'd0);
        check("pls_q_drained", {32'd0, pls_q.size()}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
